mna_req_scheduler: RTL

- Sequences master-side NoC request packets and shares the single NoC injection port between NUM_REQ request sources (e.g. AXI read and AXI write packetizers).
- Per packet: arbitrates round-robin between sources, allocates one free virtual channel from is_allocatable, then emits header, optional body, and tail flits.
- Each flit is emitted only while the allocated VC's on/off credit bit is on.
- Sits between the request packetizers and the router local input port.

---
 rtl/mna_req_if.sv | 25 ++
 rtl/mna_req_scheduler.sv | 87 ++++++++
 2 files changed

// File: rtl/mna_req_if.sv
// mna_req_if: request-source and NoC injection-port bundle for mna_req_scheduler
// Ports (slave = scheduler side):
//   req_valid/req_has_body/req_header/req_body/req_tail  in  per-source packet request, packed by source
//   req_ready/req_done                                   out grant and tail-emitted pulse per source
//   is_allocatable/is_on_off                             in  per-VC free and credit bits
//   noc_data/is_valid/vc_sel/busy                        out flit stream toward the router
interface mna_req_if #(
    parameter int NUM_REQ = 2,
    parameter int FLIT_W  = 34,
    parameter int NUM_VC  = 8
);
    logic [NUM_REQ-1:0]        req_valid, req_has_body, req_ready, req_done;
    logic [NUM_REQ*FLIT_W-1:0] req_header, req_body, req_tail;
    logic [NUM_VC-1:0]         is_allocatable, is_on_off, vc_sel;
    logic [FLIT_W-1:0]         noc_data;
    logic                      is_valid, busy;
    modport master (
        output req_valid, req_has_body, req_header, req_body, req_tail, is_allocatable, is_on_off,
        input  req_ready, req_done, noc_data, is_valid, vc_sel, busy
    );
    modport slave (
        input  req_valid, req_has_body, req_header, req_body, req_tail, is_allocatable, is_on_off,
        output req_ready, req_done, noc_data, is_valid, vc_sel, busy
    );
endinterface

// File: rtl/mna_req_scheduler.sv
// mna_req_scheduler: round-robin packet sequencer sharing one NoC injection port between request sources
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of mna_req_if (request handshake, VC allocation/credit, flit output)
module mna_req_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int FLIT_W  = 34,
    parameter int NUM_VC  = 8
) (
    input logic clk,
    input logic rst,
    mna_req_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [2:0] {IDLE, ALLOC, HEAD, BODY, TAIL} state_t;
    state_t            state;
    logic [IW-1:0]     ptr, win, pick, cand;
    logic              found, fire, has_body;
    logic [FLIT_W-1:0] hdr, bdy, tl, cur;
    logic [NUM_VC-1:0] lowest;
    // first valid source at or after the round-robin pointer
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end
    assign bus.req_ready = (state == IDLE && found) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << pick : '0;
    assign bus.busy      = state != IDLE;
    // isolate the lowest set bit of the free-VC mask
    assign lowest = bus.is_allocatable & (~bus.is_allocatable + NUM_VC'(1));
    // vc_sel is still set during the IDLE cycle carrying the tail, so gate on flit states
    assign fire = (state == HEAD || state == BODY || state == TAIL) && |(bus.is_on_off & bus.vc_sel);
    assign cur  = state == HEAD ? hdr : state == BODY ? bdy : tl;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            win          <= '0;
            has_body     <= 1'b0;
            hdr          <= '0;
            bdy          <= '0;
            tl           <= '0;
            bus.noc_data <= '0;
            bus.is_valid <= 1'b0;
            bus.vc_sel   <= '0;
            bus.req_done <= '0;
        end else begin
            bus.is_valid <= fire;
            bus.req_done <= '0;
            if (fire)
                bus.noc_data <= cur;
            case (state)
                IDLE: begin
                    bus.vc_sel <= '0;
                    if (found) begin
                        hdr      <= bus.req_header[pick*FLIT_W +: FLIT_W];
                        bdy      <= bus.req_body[pick*FLIT_W +: FLIT_W];
                        tl       <= bus.req_tail[pick*FLIT_W +: FLIT_W];
                        has_body <= bus.req_has_body[pick];
                        win      <= pick;
                        state    <= ALLOC;
                    end
                end
                ALLOC: if (|bus.is_allocatable) begin
                    bus.vc_sel <= lowest;
                    state      <= HEAD;
                end
                HEAD: if (fire) state <= has_body ? BODY : TAIL;
                BODY: if (fire) state <= TAIL;
                TAIL: if (fire) begin
                    state             <= IDLE;
                    bus.req_done[win] <= 1'b1;
                    ptr               <= win == IW'(NUM_REQ-1) ? '0 : win + IW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
